line_scan: RTL and testbench

- Sits directly downstream of the VRAM row-read engine in the Tetris playfield path.
- After a piece locks, it sweeps every playfield row through the engine's row_ld/row/row_ready handshake.
- For each row it checks the 10 returned cell words and flags the row as full when no cell holds the background colour.
- It reports a per-row full mask, this sweep's line count and a saturating lifetime line total, for the line-clear and score logic.

---
 rtl/line_scan.sv | 123 ++++++++++++
 tb/tb_line_scan.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_scan.sv
// Post-lock playfield row scanner: sweeps every row through the VRAM row-read
// engine and reports which rows are completely filled, plus a saturating line total.
module line_scan #(
  parameter int          NUM_ROWS  = 20,
  parameter int          ROW_WIDTH = 10,
  parameter logic [15:0] BG_CLR    = 16'h000F,
  parameter int          TIMEOUT   = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    row_ready,
  input  logic [16*ROW_WIDTH-1:0] read_reg,
  output logic                    row_ld,
  output logic [7:0]              row,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [NUM_ROWS-1:0]     full_mask,
  output logic [4:0]              full_count,
  output logic [15:0]             lines_total,
  output logic [2:0]              fsm_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    EVAL = 3'd2,
    NEXT = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam int                TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [7:0]        LAST_ROW = 8'(NUM_ROWS - 1);
  localparam logic [NUM_ROWS-1:0] ROW_ONE = NUM_ROWS'(1);

  state_t                  state;
  logic [TW-1:0]           tmo;
  logic [16*ROW_WIDTH-1:0] cap;
  logic                    row_full;

  // Request drops in the same cycle row_ready rises, so the engine never sees a stale request.
  assign row_ld    = (state == WAIT) & ~row_ready;
  assign fsm_state = state;

  always_comb begin
    row_full = 1'b1;
    for (int i = 0; i < ROW_WIDTH; i++) begin
      if (cap[16*i +: 16] == BG_CLR) row_full = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      row         <= 8'd0;
      full_mask   <= '0;
      full_count  <= 5'd0;
      lines_total <= 16'd0;
      done        <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
      tmo         <= '0;
      cap         <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            full_mask  <= '0;
            full_count <= 5'd0;
            row        <= 8'd0;
            tmo        <= '0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (row_ready) begin
            cap   <= read_reg;
            state <= EVAL;
          end else if (tmo == TO_LAST) begin
            // Partial sweep results are left in place for inspection.
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        EVAL: begin
          if (row_full) begin
            full_mask  <= full_mask | (ROW_ONE << row);
            full_count <= full_count + 5'd1;
            if (lines_total != 16'hFFFF) lines_total <= lines_total + 16'd1;
          end
          state <= NEXT;
        end
        NEXT: begin
          if (row == LAST_ROW) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            row   <= row + 8'd1;
            tmo   <= '0;
            state <= WAIT;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_scan.sv
// Bench for line_scan: a row-read engine model answers row_ld requests with
// configurable rows; sweeps are table-driven, corner cases are hand-written.
module tb_line_scan;

  logic         clk;
  logic         reset;
  logic         start;
  logic         row_ready;
  logic [159:0] read_reg;
  logic         row_ld;
  logic [7:0]   row;
  logic         busy;
  logic         done;
  logic         error;
  logic [19:0]  full_mask;
  logic [4:0]   full_count;
  logic [15:0]  lines_total;
  logic [2:0]   fsm_state;

  line_scan dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .row_ready   (row_ready),
    .read_reg    (read_reg),
    .row_ld      (row_ld),
    .row         (row),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .full_mask   (full_mask),
    .full_count  (full_count),
    .lines_total (lines_total),
    .fsm_state   (fsm_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [19:0] full;
    logic [19:0] part;
    int          bg;
    int          lat;
    bit          mid_start;
    bit          done_start;
    logic [19:0] exp_mask;
    logic [4:0]  exp_count;
    logic [15:0] exp_total;
  } vec_t;

  vec_t        tbl[7];
  int          total, bad;
  int          done_cnt, err_cnt, ld_clash, row_moves, cyc, wait_cnt;
  int          wait3_cyc, err_cyc, cur_lat, cur_bg;
  logic [19:0] cur_full, cur_part;
  logic [7:0]  no_resp_row, wait_row;
  bit          resp_en, prev_ld;
  logic [7:0]  req_q[$];
  logic [7:0]  exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] make_row(input logic [7:0] r);
    logic [159:0] v;
    v = '0;
    for (int i = 0; i < 10; i++) begin
      if (cur_full[r[4:0]] || (cur_part[r[4:0]] && i != cur_bg))
        v[16*i +: 16] = 16'h0F00 | 16'(i);
      else
        v[16*i +: 16] = 16'h000F;
    end
    return v;
  endfunction

  // engine model and protocol monitor
  initial begin
    row_ready = 1'b0;
    read_reg  = '0;
    wait_cnt  = 0;
    prev_ld   = 1'b0;
    cyc       = 0;
    wait_row  = 8'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      if (error) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = cyc;
      end
      if (row_ld && !prev_ld) begin
        req_q.push_back(row);
        wait_row = row;
        if (row == 8'd3) wait3_cyc = cyc;
      end
      if (row_ld && row != wait_row) row_moves++;
      prev_ld = row_ld;
      if (resp_en) begin
        if (row_ready) begin
          row_ready = 1'b0;
        end else if (row_ld && row != no_resp_row) begin
          if (wait_cnt >= cur_lat) begin
            read_reg  = make_row(row);
            row_ready = 1'b1;
            wait_cnt  = 0;
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
      #1;
      if (row_ready && row_ld) ld_clash++;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_sweep(input vec_t v, input string tag);
    bit finished;
    cur_full    = v.full;
    cur_part    = v.part;
    cur_bg      = v.bg;
    cur_lat     = v.lat;
    no_resp_row = 8'hFF;
    resp_en     = 1'b1;
    req_q.delete();
    done_cnt  = 0;
    err_cnt   = 0;
    ld_clash  = 0;
    row_moves = 0;
    pulse_start();
    check({tag, "_busy_after_start"}, busy, 1);
    finished = 1'b0;
    for (int n = 0; n < 20000 && !finished; n++) begin
      @(negedge clk);
      start = v.mid_start && (n == 30);
      if (done) begin
        finished = 1'b1;
        if (v.done_start) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          check({tag, "_start_on_done_state"}, fsm_state, 0);
          check({tag, "_start_on_done_busy"}, busy, 0);
        end
      end
    end
    check({tag, "_sweep_finished"}, finished, 1);
    repeat (2) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_error_pulses"}, err_cnt, 0);
    check({tag, "_full_mask"}, full_mask, v.exp_mask);
    check({tag, "_full_count"}, full_count, v.exp_count);
    check({tag, "_lines_total"}, lines_total, v.exp_total);
    check({tag, "_busy_idle"}, busy, 0);
    check({tag, "_ld_while_ready"}, ld_clash, 0);
    check({tag, "_row_moved_in_wait"}, row_moves, 0);
    check({tag, "_req_count"}, req_q.size(), 20);
    exp_q.delete();
    for (int r = 0; r < 20; r++) exp_q.push_back(8'(r));
    while (exp_q.size() > 0 && req_q.size() > 0)
      check({tag, "_req_row"}, req_q.pop_front(), exp_q.pop_front());
  endtask

  initial begin
    bit found;
    total     = 0;
    bad       = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    ld_clash  = 0;
    row_moves = 0;
    wait3_cyc = -1;
    err_cyc   = -1;
    cur_lat   = 0;
    cur_bg    = 0;
    cur_full  = '0;
    cur_part  = '0;
    no_resp_row = 8'hFF;
    resp_en   = 1'b0;
    start     = 1'b0;
    reset     = 1'b1;

    //           full      part      bg lat ms dn  mask      cnt    total
    tbl[0] = '{20'h00000, 20'h00000, 0, 10, 0, 0, 20'h00000, 5'd0,  16'd0};
    tbl[1] = '{20'hC0000, 20'h00000, 0, 2,  0, 0, 20'hC0000, 5'd2,  16'd2};
    tbl[2] = '{20'hC0000, 20'h00000, 0, 1,  1, 1, 20'hC0000, 5'd2,  16'd4};
    tbl[3] = '{20'h00000, 20'h00020, 9, 3,  0, 0, 20'h00000, 5'd0,  16'd4};
    tbl[4] = '{20'hFFFFF, 20'h00000, 0, 0,  0, 0, 20'hFFFFF, 5'd20, 16'd24};
    tbl[5] = '{20'h80001, 20'h00002, 0, 4,  0, 1, 20'h80001, 5'd2,  16'd26};
    tbl[6] = '{20'hAAAAA, 20'h55555, 3, 1,  0, 0, 20'hAAAAA, 5'd10, 16'd36};

    repeat (3) @(negedge clk);
    check("rst_row_ld", row_ld, 0);
    check("rst_busy", busy, 0);
    check("rst_state", fsm_state, 0);
    check("rst_mask", full_mask, 0);
    check("rst_total", lines_total, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_sweep(tbl[k], $sformatf("vec%0d", k));

    // row 3 never answered: abort after the timeout with mid-sweep results kept
    cur_full    = 20'h00005;
    cur_part    = '0;
    cur_lat     = 1;
    no_resp_row = 8'd3;
    resp_en     = 1'b1;
    req_q.delete();
    done_cnt  = 0;
    err_cnt   = 0;
    err_cyc   = -1;
    wait3_cyc = -1;
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 6000 && !found; n++) begin
      @(negedge clk);
      if (error) found = 1'b1;
    end
    check("to_error_seen", found, 1);
    repeat (2) @(negedge clk);
    check("to_latency", err_cyc - wait3_cyc, 4096);
    check("to_busy", busy, 0);
    check("to_state", fsm_state, 0);
    check("to_done_pulses", done_cnt, 0);
    check("to_error_pulses", err_cnt, 1);
    check("to_mask", full_mask, 20'h00005);
    check("to_count", full_count, 2);
    check("to_total", lines_total, 38);
    check("to_req_count", req_q.size(), 4);
    run_sweep('{20'h00000, 20'h00000, 0, 2, 0, 0, 20'h00000, 5'd0, 16'd38}, "restart");

    // saturation of the lifetime total
    @(negedge clk);
    force dut.lines_total = 16'hFFFE;
    @(negedge clk);
    release dut.lines_total;
    @(negedge clk);
    check("sat_preload", lines_total, 16'hFFFE);
    run_sweep('{20'h0F000, 20'h00000, 0, 1, 0, 0, 20'h0F000, 5'd4, 16'hFFFF}, "sat");

    // reset while waiting on row 10, then a stray row_ready
    cur_full = 20'hFFFFF;
    cur_lat  = 5;
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 3000 && !found; n++) begin
      @(negedge clk);
      if (row_ld && row == 8'd10) found = 1'b1;
    end
    check("rst_mid_found_row10", found, 1);
    reset   = 1'b1;
    resp_en = 1'b0;
    #1;
    row_ready = 1'b0;
    check("rst_mid_row_ld", row_ld, 0);
    check("rst_mid_row", row, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_error", error, 0);
    check("rst_mid_mask", full_mask, 0);
    check("rst_mid_count", full_count, 0);
    check("rst_mid_total", lines_total, 0);
    check("rst_mid_state", fsm_state, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    read_reg  = {10{16'h0F00}};
    row_ready = 1'b1;
    @(negedge clk);
    row_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_state", fsm_state, 0);
    check("stray_busy", busy, 0);
    check("stray_mask", full_mask, 0);
    check("stray_count", full_count, 0);
    check("stray_total", lines_total, 0);
    check("stray_row_ld", row_ld, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
